if_bpu_pre_dec: RTL and testbench
=================================

// Module: if_bpu_pre_dec
// PURPOSE
//  IF-stage pre-decoder plus branch predictor, successor to the fixed mini decoder.
//  - Decodes JAL/JALR/BRANCH, rs1 index and sign-extended immediate from the fetched instruction.
//  - Predicts taken/target using a parametrised 2-bit BHT trained from EX.
//  - Optional return-address stack predicts function returns.
//  Sits between the instruction fetch and the PC-select mux; the redirect is consumed in the same cycle.
// PARAMETERS
//  XLEN       32  datapath/PC width
//  BHT_DEPTH  64  BHT entries; power of 2, >=2
//  RAS_DEPTH  4   RAS entries; power of 2, >=2 (used only with IF_BPU_RAS_EN)
// PORTS
//  clk                 in   1          core clock
//  rst_n               in   1          async reset, active low
//  if_vld_i            in   1          if_instr_i/if_pc_i valid this cycle
//  if_stall_i          in   1          IF held; no RAS state change
//  if_pc_i             in   XLEN       PC of fetched instruction
//  if_instr_i          in   32         fetched instruction
//  ex_upd_vld_i        in   1          EX resolved a conditional branch
//  ex_upd_pc_i         in   XLEN       PC of resolved branch
//  ex_upd_taken_i      in   1          actual outcome
//  ex_flush_i          in   1          pipeline flush (mispredict/trap)
//  bpu_jal_o           out  1          instr is JAL
//  bpu_jalr_o          out  1          instr is JALR
//  bpu_branch_o        out  1          instr is conditional branch
//  bpu_rs1_idx_o       out  5          instr[19:15]
//  bpu_imm_o           out  XLEN       J/I/B immediate, sign-extended; 0 for other opcodes
//  bpu_pred_taken_o    out  1          redirect fetch
//  bpu_pred_target_o   out  XLEN       redirect PC; 0 when bpu_pred_taken_o=0
// BEHAVIOUR
//  - Decode and prediction outputs are combinational from inputs and current state (0-cycle latency).
//  - Decode/pred outputs are all 0 when if_vld_i=0.
//  - Async reset: BHT counters=2'b01 (weak not-taken); RAS ptr=0, cnt=0.
//  - Opcodes: JAL 1101111, JALR 1100111, BRANCH 1100011; anything else decodes as none.
//  - BHT index = pc[log2(BHT_DEPTH)+1:2]; the same slice of ex_upd_pc_i selects the update entry.
//  - JAL: taken=1, target = pc+imm (mod 2^XLEN).
//  - BRANCH: taken = ctr[1]; target = pc+imm.
//  - JALR: not predicted unless IF_BPU_RAS_EN (see below).
//  - BHT update on ex_upd_vld_i: saturating counter, +1 if taken (max 3), -1 if not (min 0).
//    Written at the clk edge.
//  - Simultaneous lookup and update of the same index: lookup sees the old value (no bypass).
//  - ex_flush_i does not modify the BHT.
// CONFIGURATION
//  IF_BPU_RAS_EN defined:
//  - link(r) = (r==x1 || r==x5).
//  - An event requires if_vld_i & !if_stall_i & !ex_flush_i.
//  - Push pc+4 on JAL/JALR with link(rd).
//  - Pop on JALR with link(rs1) & !link(rd).
//  - JALR with link(rs1) & link(rd) & rs1!=rd: pop then push, i.e. replace top with pc+4; ptr unchanged.
//  - JALR pop with cnt>0: taken=1, target = top & ~1. Empty: not predicted, no pointer change.
//  - Push when full: circular overwrite of the oldest entry; cnt saturates at RAS_DEPTH.
//  - ex_flush_i: cnt<=0 next edge (ptr kept); flush wins over a same-cycle push/pop.
//  IF_BPU_RAS_EN undefined:
//  - No RAS storage; JALR is never predicted.
//  - RAS_DEPTH is ignored.
// TESTING
//  1. Reset, BEQ at 0x100 with imm=-8 -> branch=1, imm=0xFFFFFFF8, taken=0, target=0.
//  2. Two ex_upd taken @0x100, then refetch -> taken=1, target=0xF8.
//     Four not-taken updates -> ctr=0, taken=0.
//  3. JAL x1,+0x20 @0x200 -> taken=1, target=0x220.
//     [RAS] then JALR x0,0(x1) -> taken=1, target=0x204.
//  4. [RAS] RAS_DEPTH+1 calls from 0x10,0x20,.. then RAS_DEPTH+1 rets ->
//     first RAS_DEPTH rets predict in LIFO order; last ret predicts nothing.
//  5. Same-cycle update and lookup of index 5 at ctr=1, taken update -> pred uses 1 (not-taken);
//     next cycle ctr=2, predicts taken.
//  6. Assert rst_n low mid-stream after training -> all counters read 01; RAS empty (no JALR pred).

Source files
------------

// File: rtl/if_bpu_pre_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_bpu_pre_dec                                              |
// | IF pre-decoder with 2-bit BHT predictor; RAS under IF_BPU_RAS_EN.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module if_bpu_pre_dec #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_vld_i,
    input  logic            if_stall_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    input  logic            ex_upd_vld_i,
    input  logic [XLEN-1:0] ex_upd_pc_i,
    input  logic            ex_upd_taken_i,
    input  logic            ex_flush_i,
    output logic            bpu_jal_o,
    output logic            bpu_jalr_o,
    output logic            bpu_branch_o,
    output logic [4:0]      bpu_rs1_idx_o,
    output logic [XLEN-1:0] bpu_imm_o,
    output logic            bpu_pred_taken_o,
    output logic [XLEN-1:0] bpu_pred_target_o
);

    localparam int unsigned C_BHT_IW  = $clog2(BHT_DEPTH);
    localparam logic [6:0]  C_OP_JAL  = 7'b1101111;
    localparam logic [6:0]  C_OP_JALR = 7'b1100111;
    localparam logic [6:0]  C_OP_BR   = 7'b1100011;

    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_br;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rel_target;
    logic            w_ras_pred;
    logic [XLEN-1:0] w_ras_target;
    logic            unused_inputs;

    assign w_is_jal  = if_vld_i && (if_instr_i[6:0] == C_OP_JAL);
    assign w_is_jalr = if_vld_i && (if_instr_i[6:0] == C_OP_JALR);
    assign w_is_br   = if_vld_i && (if_instr_i[6:0] == C_OP_BR);

    assign w_imm_j = {{(XLEN-20){if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                      if_instr_i[30:21], 1'b0};
    assign w_imm_i = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[31:20]};
    assign w_imm_b = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                      if_instr_i[11:8], 1'b0};

    always_comb begin
        w_imm = '0;
        if (w_is_jal)       w_imm = w_imm_j;
        else if (w_is_jalr) w_imm = w_imm_i;
        else if (w_is_br)   w_imm = w_imm_b;
    end

    assign w_rel_target  = if_pc_i + w_imm;
    assign bpu_jal_o     = w_is_jal;
    assign bpu_jalr_o    = w_is_jalr;
    assign bpu_branch_o  = w_is_br;
    assign bpu_rs1_idx_o = if_vld_i ? if_instr_i[19:15] : 5'd0;
    assign bpu_imm_o     = w_imm;

    // ------------------------------------------------------------------
    // Branch history table: lookup reads the registered value only, so a
    // same-cycle update of the same entry is seen one cycle later.
    // ------------------------------------------------------------------
    logic [1:0]          bht_q [BHT_DEPTH];
    logic [1:0]          bht_d [BHT_DEPTH];
    logic [C_BHT_IW-1:0] w_lk_idx;
    logic [C_BHT_IW-1:0] w_upd_idx;
    logic [1:0]          w_upd_ctr;
    logic                w_bht_taken;

    assign w_lk_idx    = if_pc_i[C_BHT_IW+1:2];
    assign w_upd_idx   = ex_upd_pc_i[C_BHT_IW+1:2];
    assign w_upd_ctr   = bht_q[w_upd_idx];
    assign w_bht_taken = bht_q[w_lk_idx][1];

    always_comb begin
        bht_d = bht_q;
        if (ex_upd_vld_i) begin
            if (ex_upd_taken_i && (w_upd_ctr != 2'b11))
                bht_d[w_upd_idx] = w_upd_ctr + 2'b01;
            else if (!ex_upd_taken_i && (w_upd_ctr != 2'b00))
                bht_d[w_upd_idx] = w_upd_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

`ifdef IF_BPU_RAS_EN
    localparam int unsigned         C_RAS_PW   = $clog2(RAS_DEPTH);
    localparam logic [C_RAS_PW-1:0] C_PTR_ONE  = C_RAS_PW'(1);
    localparam logic [C_RAS_PW:0]   C_CNT_ONE  = (C_RAS_PW+1)'(1);
    localparam logic [C_RAS_PW:0]   C_CNT_FULL = (C_RAS_PW+1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0]     C_FOUR     = XLEN'(4);

    logic [XLEN-1:0]     ras_q [RAS_DEPTH];
    logic [XLEN-1:0]     ras_d [RAS_DEPTH];
    logic [C_RAS_PW-1:0] ras_ptr_q;
    logic [C_RAS_PW-1:0] ras_ptr_d;
    logic [C_RAS_PW:0]   ras_cnt_q;
    logic [C_RAS_PW:0]   ras_cnt_d;
    logic                w_rd_link;
    logic                w_rs1_link;
    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [C_RAS_PW-1:0] w_top_ptr;
    logic [XLEN-1:0]     w_link_addr;

    assign w_rd_link   = (if_instr_i[11:7] == 5'd1) || (if_instr_i[11:7] == 5'd5);
    assign w_rs1_link  = (if_instr_i[19:15] == 5'd1) || (if_instr_i[19:15] == 5'd5);
    assign w_push      = (w_is_jal || w_is_jalr) && w_rd_link;
    assign w_pop       = w_is_jalr && w_rs1_link &&
                         (!w_rd_link || (if_instr_i[19:15] != if_instr_i[11:7]));
    assign w_nonempty  = (ras_cnt_q != '0);
    // ptr names the next free slot; the top entry sits just below it
    assign w_top_ptr   = ras_ptr_q - C_PTR_ONE;
    assign w_link_addr = if_pc_i + C_FOUR;
    assign w_ras_pred  = w_pop && w_nonempty;
    assign w_ras_target = {ras_q[w_top_ptr][XLEN-1:1], 1'b0};
    assign unused_inputs = ^ex_upd_pc_i;

    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ex_flush_i) begin
            ras_cnt_d = '0;
        end else if (if_vld_i && !if_stall_i) begin
            if (w_pop && w_push && w_nonempty) begin
                ras_d[w_top_ptr] = w_link_addr;
            end else begin
                if (w_pop && w_nonempty) begin
                    ras_ptr_d = w_top_ptr;
                    ras_cnt_d = ras_cnt_q - C_CNT_ONE;
                end
                if (w_push) begin
                    ras_d[ras_ptr_q] = w_link_addr;
                    ras_ptr_d        = ras_ptr_q + C_PTR_ONE;
                    if (ras_cnt_q != C_CNT_FULL) ras_cnt_d = ras_cnt_q + C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_q     <= ras_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    assign w_ras_pred    = 1'b0;
    assign w_ras_target  = '0;
    assign unused_inputs = ^{ex_upd_pc_i, if_stall_i, ex_flush_i, (RAS_DEPTH != 0)};
`endif

    always_comb begin
        bpu_pred_taken_o  = 1'b0;
        bpu_pred_target_o = '0;
        if (w_is_jal || (w_is_br && w_bht_taken)) begin
            bpu_pred_taken_o  = 1'b1;
            bpu_pred_target_o = w_rel_target;
        end else if (w_ras_pred) begin
            bpu_pred_taken_o  = 1'b1;
            bpu_pred_target_o = w_ras_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_bpu_pre_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_if_bpu_pre_dec                                           |
// | Directed self-checking bench for if_bpu_pre_dec (IF_BPU_RAS_EN aware)|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_if_bpu_pre_dec;

    localparam logic [31:0] C_BEQ_M8   = 32'hFE010CE3; // beq x2,x0,-8
    localparam logic [31:0] C_JAL_X1   = 32'h020000EF; // jal x1,+0x20
    localparam logic [31:0] C_RET      = 32'h00008067; // jalr x0,0(x1)
    localparam logic [31:0] C_JALR_X2  = 32'h01010067; // jalr x0,0x10(x2)
    localparam logic [31:0] C_JALR_X5  = 32'h000082E7; // jalr x5,0(x1)
    localparam logic [31:0] C_ADDI     = 32'hFFF10093; // addi x1,x2,-1

    logic        clk;
    logic        rst_n;
    logic        if_vld_i;
    logic        if_stall_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_instr_i;
    logic        ex_upd_vld_i;
    logic [31:0] ex_upd_pc_i;
    logic        ex_upd_taken_i;
    logic        ex_flush_i;
    logic        bpu_jal_o;
    logic        bpu_jalr_o;
    logic        bpu_branch_o;
    logic [4:0]  bpu_rs1_idx_o;
    logic [31:0] bpu_imm_o;
    logic        bpu_pred_taken_o;
    logic [31:0] bpu_pred_target_o;

    int n_assert = 0;
    int n_fail   = 0;

    if_bpu_pre_dec dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_vld_i          (if_vld_i),
        .if_stall_i        (if_stall_i),
        .if_pc_i           (if_pc_i),
        .if_instr_i        (if_instr_i),
        .ex_upd_vld_i      (ex_upd_vld_i),
        .ex_upd_pc_i       (ex_upd_pc_i),
        .ex_upd_taken_i    (ex_upd_taken_i),
        .ex_flush_i        (ex_flush_i),
        .bpu_jal_o         (bpu_jal_o),
        .bpu_jalr_o        (bpu_jalr_o),
        .bpu_branch_o      (bpu_branch_o),
        .bpu_rs1_idx_o     (bpu_rs1_idx_o),
        .bpu_imm_o         (bpu_imm_o),
        .bpu_pred_taken_o  (bpu_pred_taken_o),
        .bpu_pred_target_o (bpu_pred_target_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic taken, input logic [31:0] target);
        chk({tag, "_taken"},  32'(bpu_pred_taken_o), 32'(taken));
        chk({tag, "_target"}, bpu_pred_target_o, target);
    endtask

    task automatic chk_all(input string tag, input logic jal, input logic jalr, input logic br,
                           input logic [4:0] rs1, input logic [31:0] imm,
                           input logic taken, input logic [31:0] target);
        chk({tag, "_jal"},    32'(bpu_jal_o),     32'(jal));
        chk({tag, "_jalr"},   32'(bpu_jalr_o),    32'(jalr));
        chk({tag, "_branch"}, 32'(bpu_branch_o),  32'(br));
        chk({tag, "_rs1"},    32'(bpu_rs1_idx_o), 32'(rs1));
        chk({tag, "_imm"},    bpu_imm_o,          imm);
        chk_pred(tag, taken, target);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        if_vld_i   = 1'b1;
        if_pc_i    = pc;
        if_instr_i = instr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if_vld_i   = 1'b0;
        if_stall_i = 1'b0;
        ex_flush_i = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        ex_upd_vld_i   = 1'b1;
        ex_upd_pc_i    = pc;
        ex_upd_taken_i = taken;
        @(posedge clk);
        #1;
        ex_upd_vld_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_vld_i = 1'b0; if_stall_i = 1'b0; if_pc_i = '0; if_instr_i = '0;
        ex_upd_vld_i = 1'b0; ex_upd_pc_i = '0; ex_upd_taken_i = 1'b0; ex_flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Invalid fetch gates every output
        if_pc_i = 32'h100; if_instr_i = C_BEQ_M8; #1;
        chk_all("idle", 0, 0, 0, 5'd0, 32'h0, 0, 32'h0);

        // Reset counters are weak not-taken
        fetch(32'h100, C_BEQ_M8);
        chk_all("beq_rst", 0, 0, 1, 5'd2, 32'hFFFFFFF8, 0, 32'h0);

        upd(32'h100, 1'b1);
        upd(32'h100, 1'b1);
        chk_all("beq_trained", 0, 0, 1, 5'd2, 32'hFFFFFFF8, 1, 32'h000000F8);
        repeat (4) upd(32'h100, 1'b0);
        chk_pred("beq_ctr0", 0, 32'h0);

        fetch(32'h180, C_ADDI);
        chk_all("addi", 0, 0, 0, 5'd2, 32'h0, 0, 32'h0);
        fetch(32'h184, C_JALR_X2);
        chk_all("jalr_x2", 0, 1, 0, 5'd2, 32'h10, 0, 32'h0);

        fetch(32'h200, C_JAL_X1);
        chk_all("jal", 1, 0, 0, 5'd0, 32'h20, 1, 32'h220);
        step();
        fetch(32'h220, C_RET);
`ifdef IF_BPU_RAS_EN
        chk_all("ret", 0, 1, 0, 5'd1, 32'h0, 1, 32'h204);
`else
        chk_all("ret", 0, 1, 0, 5'd1, 32'h0, 0, 32'h0);
`endif
        step();

`ifdef IF_BPU_RAS_EN
        // Overflow: five calls into a four-deep stack drop the oldest
        for (int i = 1; i <= 5; i++) begin
            fetch(32'(i * 16), C_JAL_X1);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            fetch(32'h400, C_RET);
            if (i < 4) chk_pred("ras_lifo", 1, 32'h54 - 32'(i * 16));
            else       chk_pred("ras_empty", 0, 32'h0);
            step();
        end

        // Link-to-link JALR pops then pushes in place
        fetch(32'h700, C_JAL_X1);
        step();
        fetch(32'h808, C_JALR_X5);
        chk_pred("ras_swap", 1, 32'h704);
        step();
        fetch(32'h900, C_RET);
        chk_pred("ras_swap_ret", 1, 32'h80C);
        step();
        fetch(32'h904, C_RET);
        chk_pred("ras_swap_empty", 0, 32'h0);
        step();

        fetch(32'hA00, C_JAL_X1);
        if_stall_i = 1'b1;
        step();
        fetch(32'hA10, C_RET);
        chk_pred("ras_stall", 0, 32'h0);
        step();

        fetch(32'hB00, C_JAL_X1);
        step();
        ex_flush_i = 1'b1;
        step();
        fetch(32'hB10, C_RET);
        chk_pred("ras_flush", 0, 32'h0);
        step();

        fetch(32'hC00, C_JAL_X1);
        ex_flush_i = 1'b1;
        step();
        fetch(32'hC10, C_RET);
        chk_pred("ras_flush_push", 0, 32'h0);
        step();
`endif

        // Same-cycle update and lookup of index 5 sees the old counter
        fetch(32'h14, C_BEQ_M8);
        ex_upd_vld_i = 1'b1; ex_upd_pc_i = 32'h14; ex_upd_taken_i = 1'b1; #1;
        chk_pred("same_cycle_old", 0, 32'h0);
        @(posedge clk);
        #1 ex_upd_vld_i = 1'b0; #1;
        chk_pred("same_cycle_new", 1, 32'h0C);

        repeat (3) upd(32'h14, 1'b1);
        upd(32'h14, 1'b0);
        chk_pred("sat_hi", 1, 32'h0C);
        upd(32'h14, 1'b0);
        chk_pred("sat_hi_dn2", 0, 32'h0);

        // Async reset mid-stream after training and a call
        fetch(32'h300, C_JAL_X1);
        step();
        upd(32'h14, 1'b1);
        upd(32'h14, 1'b1);
        fetch(32'h14, C_BEQ_M8);
        chk_pred("pre_rst", 1, 32'h0C);
        #2 rst_n = 1'b0;
        #1 chk_pred("in_rst", 0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        fetch(32'h310, C_RET);
        chk_pred("rst_ras", 0, 32'h0);
        fetch(32'h100, C_BEQ_M8);
        upd(32'h100, 1'b1);
        chk_pred("rst_ctr01", 1, 32'hF8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
